// File: rtl/window_column_collector_if.sv
// Bus between the BRAM read port / address-generator tags and the window
// collector, plus the window handshake toward the convolution stage.
interface window_column_collector_if #(
  parameter int DATA_W = 8
);
  logic [1:0]          c_in;
  logic                pad_in;
  logic                row_start;
  logic [DATA_W-1:0]   rd_data;
  logic                win_ready;
  logic                win_valid;
  logic [9*DATA_W-1:0] win_data;
  logic                ovf;

  // master: upstream tags/data source and downstream consumer
  modport master (
    output c_in, pad_in, row_start, rd_data, win_ready,
    input  win_valid, win_data, ovf
  );

  // slave: the collector itself
  modport slave (
    input  c_in, pad_in, row_start, rd_data, win_ready,
    output win_valid, win_data, ovf
  );
endinterface

// File: rtl/window_column_collector.sv
// Aligns BRAM read data with delayed phase/pad tags, builds 3-pixel columns
// and shifts them into a 3x3 window offered with a valid/ready handshake.
module window_column_collector #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  window_column_collector_if.slave bus
);

  logic [RD_LAT-1:0][1:0] r_c_dly;
  logic [RD_LAT-1:0]      r_pad_dly;
  logic [RD_LAT-1:0]      r_rs_dly;

  logic [1:0]             r_exp;
  logic [DATA_W-1:0]      r_col0;
  logic [DATA_W-1:0]      r_col1;
  logic [2:0][2:0][DATA_W-1:0] r_win;  // [row][col], col 0 oldest
  logic [1:0]             r_fill;
  logic                   r_valid;
  logic                   r_ovf;

  logic [1:0]             w_cd;
  logic                   w_pd;
  logic                   w_rsd;
  logic [DATA_W-1:0]      w_pix;
  logic [2:0][DATA_W-1:0] w_new_col;
  logic                   w_col_done;
  logic                   w_shift_ok;
  logic [1:0]             w_fill_base;
  logic [1:0]             w_fill_inc;

  // Tags reset to idle so reads still in flight at reset are never captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_dly   <= '1;
      r_pad_dly <= '0;
      r_rs_dly  <= '0;
    end else begin
      r_c_dly[0]   <= bus.c_in;
      r_pad_dly[0] <= bus.pad_in;
      r_rs_dly[0]  <= bus.row_start;
      for (int i = 1; i < RD_LAT; i++) begin
        r_c_dly[i]   <= r_c_dly[i-1];
        r_pad_dly[i] <= r_pad_dly[i-1];
        r_rs_dly[i]  <= r_rs_dly[i-1];
      end
    end
  end

  assign w_cd        = r_c_dly[RD_LAT-1];
  assign w_pd        = r_pad_dly[RD_LAT-1];
  assign w_rsd       = r_rs_dly[RD_LAT-1];
  assign w_pix       = w_pd ? '0 : bus.rd_data;
  assign w_new_col   = {w_pix, r_col1, r_col0};
  assign w_col_done  = (w_cd == 2'd2) && (r_exp == 2'd2);
  assign w_shift_ok  = !r_valid || bus.win_ready;
  assign w_fill_base = w_rsd ? 2'd0 : r_fill;
  assign w_fill_inc  = (w_fill_base == 2'd3) ? 2'd3 : w_fill_base + 2'd1;

  // Phase 0 always restarts a column; out-of-order phases drop the partial one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp  <= 2'd0;
      r_col0 <= '0;
      r_col1 <= '0;
    end else begin
      case (w_cd)
        2'd0: begin
          r_col0 <= w_pix;
          r_exp  <= 2'd1;
        end
        2'd1: begin
          if (r_exp == 2'd1) begin
            r_col1 <= w_pix;
            r_exp  <= 2'd2;
          end else begin
            r_exp <= 2'd0;
          end
        end
        2'd2:    r_exp <= 2'd0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win   <= '0;
      r_fill  <= 2'd0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_fill <= w_fill_base;
      if (w_col_done && w_shift_ok) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
          r_win[r][2] <= w_new_col[r];
        end
        r_fill  <= w_fill_inc;
        r_valid <= (w_fill_inc == 2'd3);
      end else if (w_col_done) begin
        r_ovf <= 1'b1;
      end else if (r_valid && bus.win_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.win_valid = r_valid;
  assign bus.win_data  = r_win;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_window_column_collector.sv
// Directed bench: stimulus pushes hand-computed windows into a queue, a
// negedge monitor pops and compares on every accepted window.
module tb_window_column_collector;
  localparam int W   = 8;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_column_collector_if #(.DATA_W(W)) bus();
  window_column_collector #(.DATA_W(W), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // BRAM model: value presented with c_in appears LAT cycles later
  logic [W-1:0]          mem_v = '0;
  logic [LAT-1:0][W-1:0] bram;
  always @(posedge clk) begin
    bram[0] <= mem_v;
    for (int i = 1; i < LAT; i++) bram[i] <= bram[i-1];
  end
  assign bus.rd_data = bram[LAT-1];

  int n_chk = 0, n_pass = 0, n_xfer = 0;
  logic [9*W-1:0] expq[$];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [71:0] win(
    input logic [7:0] a0, a1, a2, b0, b1, b2, c0, c1, c2);
    return {c2, c1, c0, b2, b1, b0, a2, a1, a0};
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.win_valid === 1'b1 && bus.win_ready === 1'b1) begin
      n_xfer++;
      if (expq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_window: got %h expected none", bus.win_data);
      end else begin
        chk("window", bus.win_data, expq.pop_front());
      end
    end
  end

  task automatic drive(input logic [1:0] c, input logic pad, input logic rs, input logic [7:0] v);
    @(posedge clk); #1;
    bus.c_in = c; bus.pad_in = pad; bus.row_start = rs; mem_v = v;
  endtask

  task automatic issue_col(input logic [7:0] a, b, c, input logic pad0, input logic rs);
    drive(2'd0, pad0, rs, a);
    drive(2'd1, 1'b0, 1'b0, b);
    drive(2'd2, 1'b0, 1'b0, c);
    drive(2'd3, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk); #1;
    bus.win_ready = r;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.c_in = 2'd3; bus.pad_in = 1'b0; bus.row_start = 1'b0; bus.win_ready = 1'b1;
    #1;
    chk("rst_valid", {71'b0, bus.win_valid}, 72'd0);
    chk("rst_data",  bus.win_data, 72'd0);
    chk("rst_ovf",   {71'b0, bus.ovf}, 72'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // basic fill plus latency RD_LAT+1 edges after c_in=2 is sampled
    issue_col(8'd1, 8'd2, 8'd3, 1'b0, 1'b1);
    issue_col(8'd4, 8'd5, 8'd6, 1'b0, 1'b0);
    expq.push_back(win(8'd1, 8'd4, 8'd7, 8'd2, 8'd5, 8'd8, 8'd3, 8'd6, 8'd9));
    issue_col(8'd7, 8'd8, 8'd9, 1'b0, 1'b0);
    @(negedge clk); chk("lat_e1", {71'b0, bus.win_valid}, 72'd0);
    @(negedge clk); chk("lat_e2", {71'b0, bus.win_valid}, 72'd0);
    @(negedge clk); chk("lat_e3", {71'b0, bus.win_valid}, 72'd1);

    expq.push_back(win(8'd4, 8'd7, 8'd10, 8'd5, 8'd8, 8'd11, 8'd6, 8'd9, 8'd12));
    issue_col(8'd10, 8'd11, 8'd12, 1'b0, 1'b0);
    idle(5);
    chk("xfer_basic", n_xfer, 72'd2);

    // row restart with top row padded
    issue_col(8'hAA, 8'hAA, 8'hAA, 1'b1, 1'b1);
    issue_col(8'hAA, 8'hAA, 8'hAA, 1'b1, 1'b0);
    idle(6);
    chk("xfer_restart_hold", n_xfer, 72'd2);
    expq.push_back(win(8'h00, 8'h00, 8'h00, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA));
    issue_col(8'hAA, 8'hAA, 8'hAA, 1'b1, 1'b0);
    idle(6);
    chk("xfer_pad", n_xfer, 72'd3);

    // backpressure: hold, drop next column, sticky ovf
    set_ready(1'b0);
    issue_col(8'h21, 8'h22, 8'h23, 1'b0, 1'b0);
    idle(3);
    chk("bp_valid", {71'b0, bus.win_valid}, 72'd1);
    chk("bp_data0", bus.win_data, win(8'h00, 8'h00, 8'h21, 8'hAA, 8'hAA, 8'h22, 8'hAA, 8'hAA, 8'h23));
    issue_col(8'h31, 8'h32, 8'h33, 1'b0, 1'b0);
    idle(3);
    chk("bp_ovf", {71'b0, bus.ovf}, 72'd1);
    chk("bp_data1", bus.win_data, win(8'h00, 8'h00, 8'h21, 8'hAA, 8'hAA, 8'h22, 8'hAA, 8'hAA, 8'h23));
    expq.push_back(win(8'h00, 8'h00, 8'h21, 8'hAA, 8'hAA, 8'h22, 8'hAA, 8'hAA, 8'h23));
    set_ready(1'b1);
    idle(3);
    chk("ovf_sticky", {71'b0, bus.ovf}, 72'd1);
    expq.push_back(win(8'h00, 8'h21, 8'h41, 8'hAA, 8'h22, 8'h42, 8'hAA, 8'h23, 8'h43));
    issue_col(8'h41, 8'h42, 8'h43, 1'b0, 1'b0);
    idle(5);
    chk("xfer_bp", n_xfer, 72'd5);

    // broken phase sequences: 0,1,0,1,2 keeps only the restarted column; 0,2 drops
    expq.push_back(win(8'h21, 8'h41, 8'h60, 8'h22, 8'h42, 8'h61, 8'h23, 8'h43, 8'h62));
    drive(2'd0, 1'b0, 1'b0, 8'h50);
    drive(2'd1, 1'b0, 1'b0, 8'h51);
    drive(2'd0, 1'b0, 1'b0, 8'h60);
    drive(2'd1, 1'b0, 1'b0, 8'h61);
    drive(2'd2, 1'b0, 1'b0, 8'h62);
    drive(2'd3, 1'b0, 1'b0, 8'h00);
    drive(2'd0, 1'b0, 1'b0, 8'h70);
    drive(2'd2, 1'b0, 1'b0, 8'h72);
    drive(2'd3, 1'b0, 1'b0, 8'h00);
    idle(6);
    chk("xfer_phase", n_xfer, 72'd6);

    // mid-column async reset with a window pending and ovf set
    set_ready(1'b0);
    issue_col(8'h71, 8'h72, 8'h73, 1'b0, 1'b0);
    drive(2'd0, 1'b0, 1'b0, 8'h80);
    drive(2'd1, 1'b0, 1'b0, 8'h81);
    drive(2'd2, 1'b0, 1'b0, 8'h82);
    chk("pre_rst_valid", {71'b0, bus.win_valid}, 72'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {71'b0, bus.win_valid}, 72'd0);
    chk("mid_rst_data",  bus.win_data, 72'd0);
    chk("mid_rst_ovf",   {71'b0, bus.ovf}, 72'd0);
    drive(2'd3, 1'b0, 1'b0, 8'h00);
    bus.win_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    issue_col(8'h91, 8'h92, 8'h93, 1'b0, 1'b0);
    issue_col(8'hA1, 8'hA2, 8'hA3, 1'b0, 1'b0);
    idle(5);
    chk("xfer_after_rst_hold", n_xfer, 72'd6);
    expq.push_back(win(8'h91, 8'hA1, 8'hB1, 8'h92, 8'hA2, 8'hB2, 8'h93, 8'hA3, 8'hB3));
    issue_col(8'hB1, 8'hB2, 8'hB3, 1'b0, 1'b0);
    idle(8);
    chk("xfer_total", n_xfer, 72'd7);
    chk("queue_empty", expq.size(), 72'd0);
    chk("ovf_after_rst", {71'b0, bus.ovf}, 72'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
